// File: rtl/branch_unit_rs_pkg.sv
// branch_pkg: shared widths, branch opcodes and the reservation-entry layout of branch_unit_rs.
package branch_pkg;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int OW = 3;
    localparam int HW = 4;
    localparam int AW = 32;
    localparam logic [OW-1:0] JAL  = 3'd0;
    localparam logic [OW-1:0] JALR = 3'd1;
    localparam logic [OW-1:0] BEQ  = 3'd2;
    localparam logic [OW-1:0] BNE  = 3'd3;
    localparam logic [OW-1:0] BGE  = 3'd4;
    localparam logic [OW-1:0] BLT  = 3'd5;
    localparam logic [OW-1:0] BLTU = 3'd6;
    localparam logic [OW-1:0] BGEU = 3'd7;
    typedef struct packed {
        logic                  valid;
        logic [TW-1:0]         tag;
        logic [1:0][TW-1:0]    q;
        logic [1:0][DW-1:0]    v;
        logic [DW-1:0]         imm;
        logic [OW-1:0]         opcode;
        logic [AW-1:0]         pc;
        logic [AW-1:0]         pc_next;
        logic [HW-1:0]         hist;
    } entry_t;
endpackage

// File: rtl/branch_unit_rs_if.sv
// branch_unit_rs_if: IQ issue, CDB snoop, resolution and link-broadcast signals of branch_unit_rs.
interface branch_unit_rs_if;
    import branch_pkg::*;
    logic              i_iq_valid;
    logic              i_iq_ready;
    logic [TW-1:0]     i_iq_tag;
    logic [2*TW-1:0]   i_iq_Q_flatten;
    logic [2*DW-1:0]   i_iq_V_flatten;
    logic [DW-1:0]     i_iq_imm;
    logic [OW-1:0]     i_iq_opcode;
    logic [AW-1:0]     i_iq_PC;
    logic [AW-1:0]     i_iq_PC_next;
    logic [HW-1:0]     i_iq_global_history;
    logic              i_cdb_valid;
    logic [TW-1:0]     i_cdb_tag;
    logic [DW-1:0]     i_cdb_data;
    logic              o_res_valid;
    logic [AW-1:0]     o_res_pc;
    logic [AW-1:0]     o_res_correct_pc_next;
    logic [HW-1:0]     o_res_global_history;
    logic              o_res_correct_prediction;
    logic              o_res_flush;
    logic              o_cdb_valid;
    logic              o_cdb_ready;
    logic [TW-1:0]     o_cdb_tag;
    logic [AW-1:0]     o_cdb_address;
    modport master (
        output i_iq_valid, i_iq_tag, i_iq_Q_flatten, i_iq_V_flatten, i_iq_imm, i_iq_opcode,
               i_iq_PC, i_iq_PC_next, i_iq_global_history, i_cdb_valid, i_cdb_tag, i_cdb_data,
               o_cdb_ready,
        input  i_iq_ready, o_res_valid, o_res_pc, o_res_correct_pc_next, o_res_global_history,
               o_res_correct_prediction, o_res_flush, o_cdb_valid, o_cdb_tag, o_cdb_address
    );
    modport slave (
        input  i_iq_valid, i_iq_tag, i_iq_Q_flatten, i_iq_V_flatten, i_iq_imm, i_iq_opcode,
               i_iq_PC, i_iq_PC_next, i_iq_global_history, i_cdb_valid, i_cdb_tag, i_cdb_data,
               o_cdb_ready,
        output i_iq_ready, o_res_valid, o_res_pc, o_res_correct_pc_next, o_res_global_history,
               o_res_correct_prediction, o_res_flush, o_cdb_valid, o_cdb_tag, o_cdb_address
    );
endinterface

// File: rtl/branch_unit_rs_target_calc.sv
// branch_target_calc: actual next PC and link need of one branch; BRANCH_EXT_CMP_EN adds BLT/BLTU/BGEU.
module branch_target_calc
    import branch_pkg::*;
(
    input  logic [OW-1:0] opcode,
    input  logic [DW-1:0] v0,
    input  logic [DW-1:0] v1,
    input  logic [DW-1:0] imm,
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] correct_pc_next,
    output logic          needs_link
);
    logic taken;
    always_comb begin
        taken = 1'b0;
        case (opcode)
            BEQ:     taken = v0 == v1;
            BNE:     taken = v0 != v1;
            BGE:     taken = $signed(v0) >= $signed(v1);
`ifdef BRANCH_EXT_CMP_EN
            BLT:     taken = $signed(v0) < $signed(v1);
            BLTU:    taken = v0 < v1;
            BGEU:    taken = v0 >= v1;
`endif
            default: taken = 1'b0;
        endcase
        needs_link = opcode == JAL || opcode == JALR;
        correct_pc_next = opcode == JAL  ? pc + imm :
                          opcode == JALR ? (v0 + imm) & ~AW'(1) :
                          taken          ? pc + imm : pc + AW'(4);
    end
endmodule

// File: rtl/branch_unit_rs.sv
// branch_unit_rs: in-order branch reservation station with CDB snooping, head resolve and link broadcast.
// Build with BRANCH_EXT_CMP_EN to add BLT/BLTU/BGEU.
module branch_unit_rs
    import branch_pkg::*;
#(
    parameter int BW_PROCESSOR_DATA  = DW,
    parameter int BW_TAG             = TW,
    parameter int BW_OPCODE_BRANCH   = OW,
    parameter int NUM_GLOBAL_HISTORY = HW,
    parameter int BW_ADDRESS         = AW,
    parameter int NUM_ENTRIES        = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_unit_rs_if.slave bus
);
    localparam int PW = $clog2(NUM_ENTRIES);
    entry_t                  rs [NUM_ENTRIES];
    entry_t                  h, ne;
    logic [PW-1:0]           head, tail;
    logic [PW:0]             count;
    logic [BW_ADDRESS-1:0]   calc_next;
    logic [BW_TAG-1:0]       q_in [2];
    logic                    needs_link, resolve, mispredict, alloc;
    assign h = rs[head];
    branch_target_calc u_calc (
        .opcode(h.opcode), .v0(h.v[0]), .v1(h.v[1]), .pc(h.pc), .imm(h.imm),
        .correct_pc_next(calc_next), .needs_link(needs_link)
    );
    always_comb begin
        resolve = h.valid && h.q[0] == '0 && h.q[1] == '0 &&
                  (!needs_link || !bus.o_cdb_valid || bus.o_cdb_ready);
        mispredict = resolve && calc_next != h.pc_next;
        bus.i_iq_ready = count < (PW+1)'(NUM_ENTRIES) && !mispredict && !bus.o_res_flush;
        alloc = bus.i_iq_valid && bus.i_iq_ready;
        ne = '0;
        ne.valid = 1'b1;
        ne.tag = bus.i_iq_tag;
        ne.imm = bus.i_iq_imm;
        ne.opcode = BW_OPCODE_BRANCH'(bus.i_iq_opcode);
        ne.pc = bus.i_iq_PC;
        ne.pc_next = bus.i_iq_PC_next;
        ne.hist = NUM_GLOBAL_HISTORY'(bus.i_iq_global_history);
        for (int j = 0; j < 2; j++) begin
            q_in[j] = bus.i_iq_Q_flatten[j*BW_TAG +: BW_TAG];
            // a tag broadcast in the allocation cycle would otherwise be missed forever
            ne.q[j] = bus.i_cdb_valid && q_in[j] != '0 && q_in[j] == bus.i_cdb_tag ? '0 : q_in[j];
            ne.v[j] = ne.q[j] != q_in[j] ? bus.i_cdb_data
                                          : bus.i_iq_V_flatten[j*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) rs[i] <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            bus.o_res_valid <= 1'b0;
            bus.o_res_pc <= '0;
            bus.o_res_correct_pc_next <= '0;
            bus.o_res_global_history <= '0;
            bus.o_res_correct_prediction <= 1'b0;
            bus.o_res_flush <= 1'b0;
            bus.o_cdb_valid <= 1'b0;
            bus.o_cdb_tag <= '0;
            bus.o_cdb_address <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                for (int j = 0; j < 2; j++)
                    if (rs[i].valid && rs[i].q[j] != '0 && bus.i_cdb_valid && rs[i].q[j] == bus.i_cdb_tag) begin
                        rs[i].q[j] <= '0;
                        rs[i].v[j] <= bus.i_cdb_data;
                    end
            bus.o_res_valid <= resolve;
            bus.o_res_flush <= mispredict;
            if (resolve) begin
                rs[head].valid <= 1'b0;
                head <= head + PW'(1);
                bus.o_res_pc <= h.pc;
                bus.o_res_correct_pc_next <= calc_next;
                bus.o_res_global_history <= h.hist;
                bus.o_res_correct_prediction <= !mispredict;
            end
            if (mispredict) begin
                for (int i = 0; i < NUM_ENTRIES; i++) rs[i].valid <= 1'b0;
                head <= tail;
                count <= '0;
            end else
                count <= count + (PW+1)'(alloc) - (PW+1)'(resolve);
            if (alloc) begin
                rs[tail] <= ne;
                tail <= tail + PW'(1);
            end
            if (bus.o_cdb_ready) bus.o_cdb_valid <= 1'b0;
            // the link is architectural even on a mispredict, so flush never drops it
            if (resolve && needs_link) begin
                bus.o_cdb_valid <= 1'b1;
                bus.o_cdb_tag <= h.tag;
                bus.o_cdb_address <= h.pc + BW_ADDRESS'(4);
            end
        end
    end
endmodule

// File: tb/tb_branch_unit_rs.sv
// tb_branch_unit_rs: directed vectors with a scoreboard of expected resolutions and link broadcasts.
module tb_branch_unit_rs;
    import branch_pkg::*;
    typedef struct {logic [31:0] pc; logic [31:0] nxt; logic [3:0] hist; logic ok;} res_t;
    typedef struct {logic [3:0] tag; logic [31:0] addr;} lnk_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    res_t res_q[$];
    lnk_t lnk_q[$];
    always #5 clk = ~clk;
    branch_unit_rs_if bus();
    branch_unit_rs dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [3:0] tag, input logic [7:0] q, input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] imm, input logic [2:0] op, input logic [31:0] pc,
                         input logic [31:0] pcn, input logic [3:0] hist, input logic [31:0] exp_next,
                         input bit expect_res, input bit link);
        int n = 0;
        bus.i_iq_valid = 1'b1;
        bus.i_iq_tag = tag;
        bus.i_iq_Q_flatten = q;
        bus.i_iq_V_flatten = {v1, v0};
        bus.i_iq_imm = imm;
        bus.i_iq_opcode = op;
        bus.i_iq_PC = pc;
        bus.i_iq_PC_next = pcn;
        bus.i_iq_global_history = hist;
        while (!bus.i_iq_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: pc %h never accepted, ready stayed %b", pc, bus.i_iq_ready);
        end else begin
            if (expect_res) res_q.push_back('{pc, exp_next, hist, exp_next == pcn});
            if (expect_res && link) lnk_q.push_back('{tag, pc + 32'd4});
        end
        tick();
        bus.i_iq_valid = 1'b0;
    endtask
    always @(negedge clk) begin : monitor
        res_t r;
        lnk_t l;
        if (rst_n && bus.o_res_valid) begin
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: pc %h resolved, none expected", bus.o_res_pc);
            end else begin
                r = res_q.pop_front();
                chk("res_pc", bus.o_res_pc, r.pc);
                chk("res_next", bus.o_res_correct_pc_next, r.nxt);
                chk("res_hist", 32'(bus.o_res_global_history), 32'(r.hist));
                chk("res_correct", 32'(bus.o_res_correct_prediction), 32'(r.ok));
                chk("res_flush", 32'(bus.o_res_flush), 32'(!r.ok));
            end
        end
        if (rst_n && bus.o_cdb_valid && bus.o_cdb_ready) begin
            if (lnk_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL link_unexpected: tag %h addr %h, none expected", bus.o_cdb_tag, bus.o_cdb_address);
            end else begin
                l = lnk_q.pop_front();
                chk("link_tag", 32'(bus.o_cdb_tag), 32'(l.tag));
                chk("link_addr", bus.o_cdb_address, l.addr);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.i_iq_valid = 1'b0;
        bus.i_iq_tag = '0;
        bus.i_iq_Q_flatten = '0;
        bus.i_iq_V_flatten = '0;
        bus.i_iq_imm = '0;
        bus.i_iq_opcode = '0;
        bus.i_iq_PC = '0;
        bus.i_iq_PC_next = '0;
        bus.i_iq_global_history = '0;
        bus.i_cdb_valid = 1'b0;
        bus.i_cdb_tag = '0;
        bus.i_cdb_data = '0;
        bus.o_cdb_ready = 1'b1;
        #2;
        chk("rst_res_valid", 32'(bus.o_res_valid), 0);
        chk("rst_cdb_valid", 32'(bus.o_cdb_valid), 0);
        chk("rst_flush", 32'(bus.o_res_flush), 0);
        #10 rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(bus.i_iq_ready), 1);
        // BEQ taken, operands ready, one-cycle latency
        issue(4'd1, 8'h00, 32'd5, 32'd5, 32'h20, BEQ, 32'h100, 32'h120, 4'h3, 32'h120, 1, 0);
        tick();
        chk("beq_latency", 32'(bus.o_res_valid), 1);
        tick(2);
        // BNE waiting on rs1 tag 3
        issue(4'd2, 8'h03, 32'd0, 32'd7, 32'h40, BNE, 32'h200, 32'h204, 4'h5, 32'h204, 1, 0);
        tick(2);
        chk("bne_waits", 32'(bus.o_res_valid), 0);
        bus.i_cdb_valid = 1'b1;
        bus.i_cdb_tag = 4'd3;
        bus.i_cdb_data = 32'd7;
        tick();
        bus.i_cdb_valid = 1'b0;
        chk("bne_capture_cycle", 32'(bus.o_res_valid), 0);
        tick();
        chk("bne_resolved", 32'(bus.o_res_valid), 1);
        tick(2);
        // fill four, head mispredicts, the rest are flushed
        issue(4'd3, 8'h05, 32'd0, 32'd1, 32'h40, BEQ, 32'h300, 32'h340, 4'hA, 32'h304, 1, 0);
        issue(4'd4, 8'h00, 32'd1, 32'd1, 32'h08, BEQ, 32'h310, 32'h300, 4'h1, 32'h0, 0, 0);
        issue(4'd5, 8'h00, 32'd1, 32'd2, 32'h08, BNE, 32'h320, 32'h300, 4'h2, 32'h0, 0, 0);
        issue(4'd6, 8'h00, 32'd0, 32'd0, 32'h08, JAL, 32'h330, 32'h300, 4'h3, 32'h0, 0, 0);
        chk("full_ready", 32'(bus.i_iq_ready), 0);
        bus.i_cdb_valid = 1'b1;
        bus.i_cdb_tag = 4'd5;
        bus.i_cdb_data = 32'd2;
        tick();
        bus.i_cdb_valid = 1'b0;
        chk("mispredict_ready", 32'(bus.i_iq_ready), 0);
        tick();
        chk("flush_pulse", 32'(bus.o_res_flush), 1);
        chk("flush_ready", 32'(bus.i_iq_ready), 0);
        tick();
        chk("post_flush_ready", 32'(bus.i_iq_ready), 1);
        chk("flush_drop", 32'(bus.o_res_flush), 0);
        tick(5);
        // JALR link held without grant; JAL behind it stalls
        bus.o_cdb_ready = 1'b0;
        issue(4'd6, 8'h00, 32'h203, 32'd0, 32'd4, JALR, 32'h400, 32'h206, 4'h1, 32'h206, 1, 1);
        issue(4'd7, 8'h00, 32'd0, 32'd0, 32'h10, JAL, 32'h500, 32'h510, 4'h2, 32'h510, 1, 1);
        for (int i = 0; i < 3; i++) begin
            chk("link_hold_valid", 32'(bus.o_cdb_valid), 1);
            chk("link_hold_addr", bus.o_cdb_address, 32'h404);
            tick();
        end
        chk("jal_stalled", 32'(bus.o_res_valid), 0);
        bus.o_cdb_ready = 1'b1;
        tick();
        chk("jal_granted", 32'(bus.o_res_valid), 1);
        tick(3);
        // same-cycle CDB bypass on rs2
        bus.i_cdb_valid = 1'b1;
        bus.i_cdb_tag = 4'd4;
        bus.i_cdb_data = 32'h11;
        issue(4'd9, 8'h40, 32'h11, 32'd0, 32'h08, BEQ, 32'h600, 32'h608, 4'h6, 32'h608, 1, 0);
        bus.i_cdb_valid = 1'b0;
        tick();
        chk("bypass_resolve", 32'(bus.o_res_valid), 1);
        tick(2);
        // signed compares and the optional opcodes
        issue(4'd10, 8'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, BGE, 32'h700, 32'h704, 4'h7, 32'h704, 1, 0);
        tick(3);
        issue(4'd13, 8'h00, 32'd5, 32'd5, 32'h10, BGE, 32'h730, 32'h740, 4'h8, 32'h740, 1, 0);
        tick(3);
        issue(4'd11, 8'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, BLTU, 32'h710, 32'h714, 4'h9, 32'h714, 1, 0);
        tick(3);
`ifdef BRANCH_EXT_CMP_EN
        issue(4'd12, 8'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, BLT, 32'h720, 32'h724, 4'hB, 32'h740, 1, 0);
`else
        issue(4'd12, 8'h00, 32'hFFFF_FFFF, 32'd1, 32'h20, BLT, 32'h720, 32'h724, 4'hB, 32'h724, 1, 0);
`endif
        tick(3);
        // reset mid-operation with a pending link and two stalled JALs
        bus.o_cdb_ready = 1'b0;
        issue(4'd14, 8'h00, 32'd0, 32'd0, 32'h40, JAL, 32'h800, 32'h840, 4'h7, 32'h840, 1, 1);
        issue(4'd1, 8'h00, 32'd0, 32'd0, 32'h40, JAL, 32'h900, 32'h940, 4'h1, 32'h0, 0, 0);
        issue(4'd2, 8'h00, 32'd0, 32'd0, 32'h40, JAL, 32'hA00, 32'hA40, 4'h2, 32'h0, 0, 0);
        tick(2);
        chk("pre_rst_link", 32'(bus.o_cdb_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_res_valid", 32'(bus.o_res_valid), 0);
        chk("async_rst_cdb_valid", 32'(bus.o_cdb_valid), 0);
        chk("async_rst_cdb_addr", bus.o_cdb_address, 0);
        chk("async_rst_res_pc", bus.o_res_pc, 0);
        lnk_q.delete();
        bus.o_cdb_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.i_iq_ready), 1);
        tick(5);
        chk("res_q_drained", 32'(res_q.size()), 0);
        chk("lnk_q_drained", 32'(lnk_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_unit_rs.md
Name: branch_unit_rs

Overview:
- Multi-entry successor to the single-slot branch unit: an NUM_ENTRIES-deep in-order branch reservation station with CDB operand snooping, resolving one branch per cycle from the head.
- Sits between the instruction queue and the PC/IQ/ROB/LSU/INT/MUL/RF flush fabric.
- Broadcasts JAL/JALR link (PC+4) on the CDB.
- Mispredict flushes all younger branches held inside the block.

Parameters:
- BW_PROCESSOR_DATA, 32, operand width
- BW_TAG, 4, reservation tag width; tag 0 means "value present"
- BW_OPCODE_BRANCH, 3, branch opcode width
- NUM_GLOBAL_HISTORY, 4, global history bits carried per branch
- BW_ADDRESS, 32, PC width
- NUM_ENTRIES, 4, station depth (power of two, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_iq_valid  in  1  IQ offers a branch
- i_iq_ready  out  1  station accepts
- i_iq_tag  in  BW_TAG  ROB tag of branch
- i_iq_Q_flatten  in  2*BW_TAG  operand tags {rs2,rs1}
- i_iq_V_flatten  in  2*BW_PROCESSOR_DATA  operand values {rs2,rs1}
- i_iq_imm  in  BW_PROCESSOR_DATA  signed immediate
- i_iq_opcode  in  BW_OPCODE_BRANCH  branch opcode
- i_iq_PC  in  BW_ADDRESS  branch PC
- i_iq_PC_next  in  BW_ADDRESS  predicted next PC
- i_iq_global_history  in  NUM_GLOBAL_HISTORY  history snapshot
- i_cdb_valid  in  1  CDB broadcast
- i_cdb_tag  in  BW_TAG  CDB tag
- i_cdb_data  in  BW_PROCESSOR_DATA  CDB value
- o_res_valid  out  1  one-cycle resolution pulse
- o_res_pc  out  BW_ADDRESS  resolved branch PC
- o_res_correct_pc_next  out  BW_ADDRESS  actual next PC
- o_res_global_history  out  NUM_GLOBAL_HISTORY  history of resolved branch
- o_res_correct_prediction  out  1  prediction matched
- o_res_flush  out  1  mispredict flush (= o_res_valid & !o_res_correct_prediction)
- o_cdb_valid  out  1  link result pending
- o_cdb_ready  in  1  CDB arbiter grant
- o_cdb_tag  out  BW_TAG  link tag
- o_cdb_address  out  BW_ADDRESS  PC+4

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - all entries invalid; head = tail = count = 0
  - all outputs 0
  - any pending CDB link is dropped.
- Allocation:
  - i_iq_ready = (count < NUM_ENTRIES) && !resolve_mispredict && !o_res_flush.
  - On handshake, write the entry at tail, tail++ (wraps modulo NUM_ENTRIES).
  - Same-cycle bypass: if i_cdb_valid && i_cdb_tag != 0 && i_iq_Q[j] == i_cdb_tag, store Q=0 and V=i_cdb_data.
- Snoop: each valid entry operand with Q != 0 and Q == i_cdb_tag on i_cdb_valid captures data and clears Q at the edge.
- Resolve: only the head resolves, when all of the following hold:
  - the head is valid
  - both registered Q == 0 (CDB data captured this cycle is usable next cycle)
  - for JAL/JALR, the link slot is free: !o_cdb_valid || o_cdb_ready.
- Resolution outcome:
  - o_res_* are registered at the resolve edge; latency from resolve cycle is 1.
  - o_res_valid drops next cycle unless another resolve occurs.
  - Throughput: one branch per cycle.
- Targets (all sums mod 2^BW_ADDRESS):
  - JAL: PC+imm
  - JALR: (V0+imm) with bit0 cleared
  - BEQ/BNE/BGE: taken gives PC+imm, else PC+4; BGE is a signed compare.
- Prediction check: correct_prediction = (computed next == stored PC_next).
- Mispredict at resolve edge:
  - all remaining entries are invalidated
  - head = tail, count = 0
  - no allocation that cycle
  - o_res_flush pulses the following cycle.
- Link slot: JAL/JALR resolve (correct or not) loads o_cdb_tag/o_cdb_address = PC+4 and sets o_cdb_valid. It holds until o_cdb_ready and is never cleared by flush.
- count updates: simultaneous allocate and resolve leaves count unchanged; full with resolve in the same cycle still does not accept (ready uses the registered count).
- Unknown opcode: not taken, PC+4, no link.

Optional Feature:
- Macro BRANCH_EXT_CMP_EN.
- Defined: adds BLT (signed <), BLTU (unsigned <), BGEU (unsigned >=) at opcodes 5/6/7.
- Undefined: opcodes 5–7 take the unknown-opcode path (PC+4, no link).

Decomposition:
- Package branch_pkg holds:
  - opcode constants JAL=0, JALR=1, BEQ=2, BNE=3, BGE=4, BLT=5, BLTU=6, BGEU=7
  - the entry struct typedef (valid, tag, Q[2], V[2], imm, opcode, PC, PC_next, history)
- One combinational sub-module branch_target_calc: opcode/operands/PC/imm in, correct_pc_next and needs_link out.

Test Plan:
- BEQ, operands ready, V0=V1=5, PC=0x100, imm=0x20, PC_next=0x120 -> o_res_valid one cycle later; correct_pc_next=0x120, correct_prediction=1, flush=0.
- BNE with Q0=3 pending; CDB tag3 data=7 arrives with V1=7 -> resolves the cycle after capture; not taken, correct_pc_next=PC+4.
- Fill 4 entries, head mispredicts -> o_res_flush=1; remaining 3 entries never resolve; i_iq_ready low in resolve and flush cycles, high afterward; count=0.
- JALR V0=0x203, imm=4, o_cdb_ready=0 for 3 cycles -> correct_pc_next=0x206; o_cdb_valid held with address=PC+4; a following JAL stalls until grant.
- CDB tag matches an IQ operand in the allocation cycle -> the entry stores the value; resolves without waiting.
- BRANCH_EXT_CMP_EN on: BLTU V0=0xFFFFFFFF, V1=1 -> not taken; BLT with the same operands -> taken. Macro off -> opcode 5 gives PC+4.
- rst_n asserted with 2 entries and a pending link -> all outputs 0 immediately; i_iq_ready=1 after release.
